// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the MIPS16 HI/LO multiply/divide unit.
// Used by the interface, the top-level FSM and the single-iteration datapath step.
package mult_div_unit_pkg;

   // Default operand width of the core; results are twice this wide.
   localparam int MULDIV_WIDTH = 16;

   // Operation encoding as issued by the decoder.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_t;

   // Sequencer states, also exported for observation.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } muldiv_state_t;

   // Signed variants take magnitudes at capture and fix the sign afterwards.
   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle of the multiply/divide unit.
// Request side: start/op/opa/opb are sampled together on the edge that accepts the
// operation (state IDLE or DONE); start is ignored at every other edge, with no queueing.
// Result side: done is a one-cycle pulse, and hi/lo/result/div_by_zero are valid from
// that cycle and held until the next result load.
// Optional macro MULDIV_FLUSH_EN adds the flush input.
interface mult_div_unit_if
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
);
   logic                 start;
   logic [1:0]           op;
   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     opb;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;
   logic [2*WIDTH-1:0]   result;
   muldiv_state_t        state_dbg;
`ifdef MULDIV_FLUSH_EN
   logic                 flush;

   modport master (
      output start, op, opa, opb, flush,
      input  busy, done, div_by_zero, hi, lo, result, state_dbg
   );
   modport slave (
      input  start, op, opa, opb, flush,
      output busy, done, div_by_zero, hi, lo, result, state_dbg
   );
`else
   modport master (
      output start, op, opa, opb,
      input  busy, done, div_by_zero, hi, lo, result, state_dbg
   );
   modport slave (
      input  start, op, opa, opb,
      output busy, done, div_by_zero, hi, lo, result, state_dbg
   );
`endif
endinterface

// File: rtl/mult_div_unit_step.sv
// One iteration of the iterative multiply/divide datapath.
// Multiply: right-shifting shift-add over {p, a}; a holds the remaining multiplier bits.
// Divide: restoring shift-subtract; p is the partial remainder, a shifts the dividend
// out of its top and the quotient bits in at its bottom.
module mult_div_unit_step
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   p_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH:0]   p_out,
   output logic [WIDTH-1:0] a_out
);
   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   trial;
   logic             fits;

   // Single combinational step: add-or-pass for multiply, trial-subtract for divide.
   always_comb begin
      sum     = {1'b0, p_in[WIDTH-1:0]} + (a_in[0] ? {1'b0, b_in} : '0);
      shifted = {p_in, a_in[WIDTH-1]};
      fits    = (shifted >= {2'b00, b_in});
      trial   = shifted[WIDTH:0] - {1'b0, b_in};
      if (is_div) begin
         p_out = fits ? trial : shifted[WIDTH:0];
         a_out = {a_in[WIDTH-2:0], fits};
      end else begin
         p_out = {1'b0, sum[WIDTH:1]};
         a_out = {sum[0], a_in[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit, one result bit per cycle.
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX (sign fix + load) -> DONE -> IDLE,
// with DONE able to accept a new start directly.
// Optional macro MULDIV_FLUSH_EN adds a flush input that abandons CALC/FIX.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input logic             clk,
   input logic             rst_n,
   mult_div_unit_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   muldiv_state_t     state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH:0]    p_q, p_d;
   logic              is_div_q, is_div_d;
   logic              neg_prod_q, neg_prod_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dbz_op_q, dbz_op_d;
   logic [WIDTH-1:0]  opa_raw_q, opa_raw_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;

   muldiv_op_t        op_in;
   logic              flush_in;
   logic              accept;
   logic              sa, sb;
   logic [WIDTH-1:0]  opa_mag, opb_mag;
   logic [WIDTH:0]    step_p;
   logic [WIDTH-1:0]  step_a;
   logic [2*WIDTH-1:0] prod_mag, prod_fix;
   logic [WIDTH-1:0]  quo_fix, rem_fix;

`ifdef MULDIV_FLUSH_EN
   assign flush_in = bus.flush;
`else
   assign flush_in = 1'b0;
`endif

   assign op_in = muldiv_op_t'(bus.op);

   mult_div_unit_step #(.WIDTH(WIDTH)) u_muldiv_step (
      .is_div (is_div_q),
      .p_in   (p_q),
      .a_in   (a_q),
      .b_in   (b_q),
      .p_out  (step_p),
      .a_out  (step_a)
   );

   // Operand magnitudes at capture and sign-corrected results for the FIX load.
   always_comb begin
      sa       = op_is_signed(op_in) & bus.opa[WIDTH-1];
      sb       = op_is_signed(op_in) & bus.opb[WIDTH-1];
      opa_mag  = sa ? -bus.opa : bus.opa;
      opb_mag  = sb ? -bus.opb : bus.opb;
      prod_mag = {p_q[WIDTH-1:0], a_q};
      prod_fix = neg_prod_q ? -prod_mag : prod_mag;
      quo_fix  = neg_prod_q ? -a_q : a_q;
      rem_fix  = neg_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
   end

   // Next-state, datapath and registered-output logic of the sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      p_d        = p_q;
      is_div_d   = is_div_q;
      neg_prod_d = neg_prod_q;
      neg_rem_d  = neg_rem_q;
      dbz_op_d   = dbz_op_q;
      opa_raw_d  = opa_raw_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dbz_d      = dbz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      accept     = 1'b0;

      case (state_q)
         ST_IDLE: accept = bus.start;
         ST_CALC: begin
            a_d = step_a;
            p_d = step_p;
            if (cnt_q == '0) state_d = ST_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_FIX: begin
            if (dbz_op_q) begin
               hi_d = opa_raw_q;
               lo_d = '1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            dbz_d   = dbz_op_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
            // A flush in DONE has no effect of its own but drops a coincident start.
            accept  = bus.start & ~flush_in;
         end
      endcase

      // Abandoning an operation leaves the previous result and flag untouched.
      if (flush_in && (state_q == ST_CALC || state_q == ST_FIX)) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dbz_d   = dbz_q;
      end

      if (accept) begin
         state_d    = ST_CALC;
         cnt_d      = CW'(WIDTH - 1);
         busy_d     = 1'b1;
         dbz_d      = 1'b0;
         a_d        = opa_mag;
         b_d        = opb_mag;
         p_d        = '0;
         is_div_d   = op_is_div(op_in);
         neg_prod_d = sa ^ sb;
         neg_rem_d  = sa;
         dbz_op_d   = op_is_div(op_in) && (bus.opb == '0);
         opa_raw_d  = bus.opa;
      end
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         p_q        <= '0;
         is_div_q   <= 1'b0;
         neg_prod_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_op_q   <= 1'b0;
         opa_raw_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         p_q        <= p_d;
         is_div_q   <= is_div_d;
         neg_prod_q <= neg_prod_d;
         neg_rem_q  <= neg_rem_d;
         dbz_op_q   <= dbz_op_d;
         opa_raw_q  <= opa_raw_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.result      = {hi_q, lo_q};
   assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for
// start-while-busy, back-to-back, mid-operation reset and (with MULDIV_FLUSH_EN) flush.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W       = 16;
   localparam int LAT     = W + 2;
   localparam int BUSY_N  = W + 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mult_div_unit_if #(.WIDTH(W)) mdu_if ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mdu_if)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_hi;
      logic [15:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Driver: present a request and hold start across exactly one rising edge.
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      mdu_if.op    = op;
      mdu_if.opa   = a;
      mdu_if.opb   = b;
      mdu_if.start = 1'b1;
      @(posedge clk);
      #1;
      mdu_if.start = 1'b0;
   endtask

   // Count edges until done, track busy cycles and result stability while busy.
   task automatic wait_done(input int start_edges, output int edges, output int busy_cycles,
                            output bit seen, output bit held);
      logic [31:0] prev;
      prev        = mdu_if.result;
      edges       = start_edges;
      busy_cycles = mdu_if.busy ? 1 : 0;
      seen        = 1'b0;
      held        = 1'b1;
      while (!seen && edges < start_edges + 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (mdu_if.done) seen = 1'b1;
         else if (mdu_if.busy) begin
            busy_cycles++;
            if (mdu_if.result !== prev) held = 1'b0;
         end
      end
   endtask

   int  e, bc;
   bit  seen, held;
   bit  done_any;

   initial begin
      checks = 0;
      errors = 0;
      rst_n        = 1'b0;
      mdu_if.start = 1'b0;
      mdu_if.op    = 2'b00;
      mdu_if.opa   = '0;
      mdu_if.opb   = '0;
`ifdef MULDIV_FLUSH_EN
      mdu_if.flush = 1'b0;
`endif

      //             op         a         b         hi        lo        dbz
      vecs[0]  = '{2'b01, 16'hFFFF, 16'h0002, 16'h0001, 16'hFFFE, 1'b0};
      vecs[1]  = '{2'b00, 16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 1'b0};
      vecs[2]  = '{2'b00, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
      vecs[3]  = '{2'b10, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
      vecs[4]  = '{2'b11, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0};
      vecs[5]  = '{2'b11, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
      vecs[6]  = '{2'b01, 16'h0003, 16'h0003, 16'h0000, 16'h0009, 1'b0};
      vecs[7]  = '{2'b10, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
      vecs[8]  = '{2'b10, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
      vecs[9]  = '{2'b00, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000, 1'b0};
      vecs[10] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
      vecs[11] = '{2'b10, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1};
      vecs[12] = '{2'b11, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
      vecs[13] = '{2'b10, 16'h0064, 16'hFFF9, 16'h0002, 16'hFFF2, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_busy",  {31'd0, mdu_if.busy}, 32'd0);
      check("rst_done",  {31'd0, mdu_if.done}, 32'd0);
      check("rst_dbz",   {31'd0, mdu_if.div_by_zero}, 32'd0);
      check("rst_result", mdu_if.result, 32'd0);
      check("rst_state", {30'd0, mdu_if.state_dbg}, {30'd0, ST_IDLE});

      // Vector table
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(1, e, bc, seen, held);
         check($sformatf("v%0d_done_seen", i), {31'd0, seen}, 32'd1);
         check($sformatf("v%0d_latency", i), e, LAT);
         check($sformatf("v%0d_busy_cycles", i), bc, BUSY_N);
         check($sformatf("v%0d_hold_while_busy", i), {31'd0, held}, 32'd1);
         check($sformatf("v%0d_hi", i), {16'd0, mdu_if.hi}, {16'd0, vecs[i].exp_hi});
         check($sformatf("v%0d_lo", i), {16'd0, mdu_if.lo}, {16'd0, vecs[i].exp_lo});
         check($sformatf("v%0d_result", i), mdu_if.result, {vecs[i].exp_hi, vecs[i].exp_lo});
         check($sformatf("v%0d_dbz", i), {31'd0, mdu_if.div_by_zero}, {31'd0, vecs[i].exp_dbz});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), {31'd0, mdu_if.done}, 32'd0);
         check($sformatf("v%0d_dbz_held", i), {31'd0, mdu_if.div_by_zero}, {31'd0, vecs[i].exp_dbz});
      end

      // Start pulsed at cycle 5 of a busy op is ignored
      issue(2'b01, 16'h0003, 16'h0005);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      mdu_if.op    = 2'b01;
      mdu_if.opa   = 16'hFFFF;
      mdu_if.opb   = 16'hFFFF;
      mdu_if.start = 1'b1;
      @(posedge clk);
      #1;
      mdu_if.start = 1'b0;
      wait_done(6, e, bc, seen, held);
      check("ign_done_seen", {31'd0, seen}, 32'd1);
      check("ign_latency", e, LAT);
      check("ign_result", mdu_if.result, 32'h0000_000F);

      // Back-to-back: start while done is high
      issue(2'b11, 16'h0064, 16'h0007);
      check("b2b_busy", {31'd0, mdu_if.busy}, 32'd1);
      wait_done(1, e, bc, seen, held);
      check("b2b_done_seen", {31'd0, seen}, 32'd1);
      check("b2b_latency", e, LAT);
      check("b2b_result", mdu_if.result, 32'h0002_000E);

      // Reset at cycle 8 of CALC aborts and clears the result
      @(posedge clk);
      #1;
      issue(2'b01, 16'hFFFF, 16'hFFFF);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      check("mid_rst_busy_before", {31'd0, mdu_if.busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mid_rst_busy", {31'd0, mdu_if.busy}, 32'd0);
      check("mid_rst_done", {31'd0, mdu_if.done}, 32'd0);
      check("mid_rst_result", mdu_if.result, 32'd0);
      check("mid_rst_state", {30'd0, mdu_if.state_dbg}, {30'd0, ST_IDLE});
      issue(2'b01, 16'h0003, 16'h0003);
      wait_done(1, e, bc, seen, held);
      check("post_rst_latency", e, LAT);
      check("post_rst_result", mdu_if.result, 32'h0000_0009);

`ifdef MULDIV_FLUSH_EN
      // Flush mid-CALC: back to IDLE, no done, result untouched
      @(posedge clk);
      #1;
      issue(2'b00, 16'h7FFF, 16'h8000);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      mdu_if.flush = 1'b1;
      @(posedge clk);
      #1;
      mdu_if.flush = 1'b0;
      check("flush_busy", {31'd0, mdu_if.busy}, 32'd0);
      check("flush_state", {30'd0, mdu_if.state_dbg}, {30'd0, ST_IDLE});
      check("flush_result", mdu_if.result, 32'h0000_0009);
      done_any = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (mdu_if.done) done_any = 1'b1;
      end
      check("flush_no_done", {31'd0, done_any}, 32'd0);

      // Flush together with start in DONE drops the start
      issue(2'b01, 16'h0002, 16'h0002);
      wait_done(1, e, bc, seen, held);
      check("fd_result", mdu_if.result, 32'h0000_0004);
      mdu_if.op    = 2'b01;
      mdu_if.opa   = 16'h0005;
      mdu_if.opb   = 16'h0005;
      mdu_if.start = 1'b1;
      mdu_if.flush = 1'b1;
      @(posedge clk);
      #1;
      mdu_if.start = 1'b0;
      mdu_if.flush = 1'b0;
      check("fd_busy", {31'd0, mdu_if.busy}, 32'd0);
      check("fd_state", {30'd0, mdu_if.state_dbg}, {30'd0, ST_IDLE});
      check("fd_result_kept", mdu_if.result, 32'h0000_0004);
`else
      done_any = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
